// File: rtl/mem_wb_stage.sv
// MEM/WB register: big-endian byte/half load extraction and two-cycle paired-load write-back.
// One-cycle latency; MEM_WB_Busy holds upstream while the second pair write is pending.
module mem_wb_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] MEM_ReadData_A,
  input  logic [31:0] MEM_ReadData_B,
  input  logic [1:0]  EX_MEM_Address,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [4:0]  EX_MEM_WriteReg,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_HalfControl,
  input  logic        EX_MEM_ByteControl,
  input  logic        EX_MEM_Unsigned,
  input  logic        EX_MEM_PairLoad,
  input  logic        Stall,
  input  logic        Flush,
  output logic        MEM_WB_RegWrite,
  output logic [4:0]  MEM_WB_WriteReg,
  output logic [31:0] MEM_WB_WriteData,
  output logic        MEM_WB_Busy
);

  typedef enum logic {S_IDLE = 1'b0, S_PAIR2 = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [4:0]  r_reg, w_reg_nxt;
  logic [31:0] r_dat, w_dat_nxt;
  logic [4:0]  r_b_reg, w_b_reg_nxt;
  logic [31:0] r_b_dat, w_b_dat_nxt;

  logic        w_pair;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_dat;

  assign w_pair = EX_MEM_MemRead & EX_MEM_PairLoad & EX_MEM_RegWrite;

  // Lane 0 is the most significant byte (big-endian).
  always_comb begin
    w_byte = 8'h00;
    case (EX_MEM_Address)
      2'd0: w_byte = MEM_ReadData_A[31:24];
      2'd1: w_byte = MEM_ReadData_A[23:16];
      2'd2: w_byte = MEM_ReadData_A[15:8];
      2'd3: w_byte = MEM_ReadData_A[7:0];
    endcase
    w_half = EX_MEM_Address[1] ? MEM_ReadData_A[15:0] : MEM_ReadData_A[31:16];

    w_ld_dat = MEM_ReadData_A;
    if (!EX_MEM_MemRead)
      w_ld_dat = EX_MEM_ALUResult;
    else if (w_pair)
      w_ld_dat = MEM_ReadData_A;
    else if (EX_MEM_ByteControl)
      w_ld_dat = EX_MEM_Unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
    else if (EX_MEM_HalfControl)
      w_ld_dat = EX_MEM_Unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_reg_nxt   = r_reg;
    w_dat_nxt   = r_dat;
    w_b_reg_nxt = r_b_reg;
    w_b_dat_nxt = r_b_dat;
    case (r_state)
      S_IDLE: begin
        if (!Stall) begin
          w_reg_nxt = EX_MEM_WriteReg;
          w_dat_nxt = w_ld_dat;
          if (Flush) begin
            w_we_nxt = 1'b0;
          end else begin
            w_we_nxt = EX_MEM_RegWrite && (EX_MEM_WriteReg != 5'd0);
            if (w_pair) begin
              w_b_dat_nxt = MEM_ReadData_B;
              w_b_reg_nxt = EX_MEM_WriteReg + 5'd1;
              w_state_nxt = S_PAIR2;
            end
          end
        end
      end
      S_PAIR2: begin
        // The pair is committed, so Flush has no effect here.
        if (!Stall) begin
          w_we_nxt    = (r_b_reg != 5'd0);
          w_reg_nxt   = r_b_reg;
          w_dat_nxt   = r_b_dat;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_reg   <= 5'd0;
      r_dat   <= 32'd0;
      r_b_reg <= 5'd0;
      r_b_dat <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_reg   <= w_reg_nxt;
      r_dat   <= w_dat_nxt;
      r_b_reg <= w_b_reg_nxt;
      r_b_dat <= w_b_dat_nxt;
    end
  end

  assign MEM_WB_RegWrite  = r_we;
  assign MEM_WB_WriteReg  = r_reg;
  assign MEM_WB_WriteData = r_dat;
  assign MEM_WB_Busy      = (r_state == S_PAIR2);

endmodule
